// File: rtl/period_meter_pkg.sv
// Shared definitions for the period meter: measurement states and default timeout.
package period_meter_pkg;

  typedef enum logic [1:0] {
    S_WAIT   = 2'd0,
    S_MEAS   = 2'd1,
    S_STABLE = 2'd2
  } state_t;

  localparam int DEFAULT_TIMEOUT = 65535;

endpackage

// File: rtl/period_meter_edge_sync.sv
// Multi-flop synchronizer for an asynchronous input followed by a rising-edge detector.
module edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic RST,
  input  logic d,
  output logic q_rise
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   last_q;

  always_ff @(posedge clk) begin
    if (RST) begin
      sync   <= '0;
      last_q <= 1'b0;
    end else begin
      sync   <= {sync[SYNC_STAGES-2:0], d};
      last_q <= sync[SYNC_STAGES-1];
    end
  end

  assign q_rise = sync[SYNC_STAGES-1] & ~last_q;

endmodule

// File: rtl/period_meter.sv
// Measures the reference clock period in sampling-clock ticks, qualifies it as
// stable after consecutive matching periods, and flags a lost reference.
module period_meter
  import period_meter_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int SYNC_STAGES  = 2,
  parameter int STABLE_COUNT = 4,
  parameter int TOLERANCE    = 1,
  parameter int TIMEOUT      = DEFAULT_TIMEOUT
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             clk_in,
  output logic [WIDTH-1:0] period,
  output logic             period_valid,
  output logic             period_stable,
  output logic             lost
);

  localparam int MW = $clog2(STABLE_COUNT + 1);
  localparam logic [WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [WIDTH-1:0] CNT_ONE   = WIDTH'(1);
  localparam logic [WIDTH-1:0] TIMEOUT_W = WIDTH'(TIMEOUT);
  localparam logic [WIDTH:0]   TOL_W     = (WIDTH + 1)'(TOLERANCE);
  localparam logic [MW-1:0]    STABLE_W  = MW'(STABLE_COUNT);
  localparam logic [MW-1:0]    MATCH_ONE = MW'(1);

  logic rise;

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_edge_sync (
    .clk    (clk),
    .RST    (RST),
    .d      (clk_in),
    .q_rise (rise)
  );

  state_t           state, state_nxt;
  logic [WIDTH-1:0] count, count_nxt, period_nxt;
  logic [MW-1:0]    match, match_nxt;
  logic             valid_nxt, stable_nxt, lost_nxt;
  logic [WIDTH:0]   cur_ext, prev_ext, diff;
  logic             in_tol, timed_out;

  // One extra bit keeps the absolute difference exact for any pair of counts.
  always_comb begin
    cur_ext   = {1'b0, count};
    prev_ext  = {1'b0, period};
    diff      = (cur_ext >= prev_ext) ? (cur_ext - prev_ext) : (prev_ext - cur_ext);
    in_tol    = (diff <= TOL_W);
    timed_out = (count == TIMEOUT_W);
  end

  always_comb begin
    state_nxt  = state;
    count_nxt  = rise ? CNT_ONE : ((count == CNT_MAX) ? count : count + CNT_ONE);
    period_nxt = period;
    valid_nxt  = 1'b0;
    stable_nxt = period_stable;
    lost_nxt   = lost;
    match_nxt  = match;

    if (rise) begin
      lost_nxt = 1'b0;
      case (state)
        S_WAIT: state_nxt = S_MEAS;
        S_MEAS, S_STABLE: begin
          period_nxt = count;
          valid_nxt  = 1'b1;
          // A zero match count marks the first capture after arming: nothing to compare yet.
          if (match == '0)
            match_nxt = MATCH_ONE;
          else if (in_tol)
            match_nxt = (match == STABLE_W) ? match : match + MATCH_ONE;
          else
            match_nxt = MATCH_ONE;

          if (state == S_STABLE && !in_tol) begin
            stable_nxt = 1'b0;
            state_nxt  = S_MEAS;
          end else if (match_nxt == STABLE_W) begin
            stable_nxt = 1'b1;
            state_nxt  = S_STABLE;
          end
        end
        default: state_nxt = S_WAIT;
      endcase
    end else if (state != S_WAIT && timed_out) begin
      lost_nxt   = 1'b1;
      stable_nxt = 1'b0;
      match_nxt  = '0;
      state_nxt  = S_WAIT;
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state         <= S_WAIT;
      count         <= '0;
      match         <= '0;
      period        <= '0;
      period_valid  <= 1'b0;
      period_stable <= 1'b0;
      lost          <= 1'b0;
    end else begin
      state         <= state_nxt;
      count         <= count_nxt;
      match         <= match_nxt;
      period        <= period_nxt;
      period_valid  <= valid_nxt;
      period_stable <= stable_nxt;
      lost          <= lost_nxt;
    end
  end

endmodule

// File: tb/tb_period_meter.sv
// Self-checking bench for period_meter: event-level reference model compared every
// cycle, plus hand-computed expectations on logged valid pulses and loss timing.
module tb_period_meter;

  localparam int WIDTH        = 32;
  localparam int SYNC         = 2;
  localparam int STABLE_COUNT = 4;
  localparam int TOLERANCE    = 1;
  localparam int TIMEOUT      = 100;
  localparam int HALF         = 5;
  localparam int TICK         = 2 * HALF;

  logic             clk    = 1'b0;
  logic             RST    = 1'b1;
  logic             clk_in = 1'b0;
  logic [WIDTH-1:0] period;
  logic             period_valid;
  logic             period_stable;
  logic             lost;

  int n_compared   = 0;
  int n_mismatched = 0;

  period_meter #(
    .WIDTH        (WIDTH),
    .SYNC_STAGES  (SYNC),
    .STABLE_COUNT (STABLE_COUNT),
    .TOLERANCE    (TOLERANCE),
    .TIMEOUT      (TIMEOUT)
  ) dut (
    .clk           (clk),
    .RST           (RST),
    .clk_in        (clk_in),
    .period        (period),
    .period_valid  (period_valid),
    .period_stable (period_stable),
    .lost          (lost)
  );

  always #HALF clk = ~clk;

  task automatic checkOutput(input string name, input logic [WIDTH-1:0] act,
                             input logic [WIDTH-1:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: reference-clock rises sampled at clk edges, seen SYNC edges later.
  int               cyc = 0;
  bit               started = 1'b0;
  bit               prev_sample = 1'b0;
  int               rise_q[$];
  bit               m_armed = 1'b0;
  int               m_last_det = 0;
  int               m_prev = 0;
  int               m_match = 0;
  logic [WIDTH-1:0] m_period = '0;
  bit               m_valid = 1'b0;
  bit               m_stable = 1'b0;
  bit               m_lost = 1'b0;

  always @(posedge clk) begin
    int p;
    int d;
    bit det;
    cyc++;
    m_valid = 1'b0;
    if (RST) begin
      started     = 1'b1;
      prev_sample = 1'b0;
      rise_q.delete();
      m_armed  = 1'b0;
      m_match  = 0;
      m_prev   = 0;
      m_period = '0;
      m_stable = 1'b0;
      m_lost   = 1'b0;
    end else begin
      if (clk_in && !prev_sample) rise_q.push_back(cyc);
      prev_sample = clk_in;
      det = 1'b0;
      if (rise_q.size() > 0 && rise_q[0] == cyc - SYNC) begin
        det = 1'b1;
        void'(rise_q.pop_front());
      end
      if (det) begin
        if (m_armed) begin
          p = cyc - m_last_det;
          d = (p > m_prev) ? p - m_prev : m_prev - p;
          m_period = WIDTH'(p);
          m_valid  = 1'b1;
          if (m_match == 0) begin
            m_match  = 1;
            m_stable = (m_match == STABLE_COUNT);
          end else if (d <= TOLERANCE) begin
            if (m_match < STABLE_COUNT) m_match++;
            if (m_match == STABLE_COUNT) m_stable = 1'b1;
          end else begin
            m_match  = 1;
            m_stable = 1'b0;
          end
          m_prev = p;
        end
        m_armed    = 1'b1;
        m_last_det = cyc;
        m_lost     = 1'b0;
      end else if (m_armed && (cyc - m_last_det) == TIMEOUT) begin
        m_lost   = 1'b1;
        m_stable = 1'b0;
        m_match  = 0;
        m_armed  = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      checkOutput("model_period", period, m_period);
      checkOutput("model_valid", WIDTH'(period_valid), WIDTH'(m_valid));
      checkOutput("model_stable", WIDTH'(period_stable), WIDTH'(m_stable));
      checkOutput("model_lost", WIDTH'(lost), WIDTH'(m_lost));
    end
  end

  // Log of valid pulses and lost transitions, used by the literal checks.
  int vq_period[$];
  int vq_stable[$];
  int vq_cyc[$];
  int lost_rise_cyc = -1;
  int lost_fall_cyc = -1;
  bit lost_d = 1'b0;

  always @(negedge clk) begin
    if (period_valid) begin
      vq_period.push_back(int'(period));
      vq_stable.push_back(int'(period_stable));
      vq_cyc.push_back(cyc);
    end
    if (lost === 1'b1 && !lost_d) lost_rise_cyc = cyc;
    if (lost === 1'b0 && lost_d) lost_fall_cyc = cyc;
    lost_d = (lost === 1'b1);
  end

  task automatic clearLog();
    vq_period.delete();
    vq_stable.delete();
    vq_cyc.delete();
    lost_rise_cyc = -1;
    lost_fall_cyc = -1;
  endtask

  task automatic checkPulse(input string name, input int idx, input int exp_period,
                            input int exp_stable);
    if (idx >= vq_period.size()) begin
      n_compared++;
      n_mismatched++;
      $display("[TB] FAIL %s: pulse %0d missing, got %0d pulses", name, idx, vq_period.size());
    end else begin
      checkOutput({name, "_period"}, WIDTH'(vq_period[idx]), WIDTH'(exp_period));
      checkOutput({name, "_stable"}, WIDTH'(vq_stable[idx]), WIDTH'(exp_stable));
    end
  endtask

  task automatic applyStimulus(input int per, input int rises);
    repeat (rises) begin
      clk_in = 1'b1;
      #((per / 2) * TICK);
      clk_in = 1'b0;
      #((per - per / 2) * TICK);
    end
  endtask

  task automatic pulseReset(input int cycles);
    RST = 1'b1;
    #(cycles * TICK);
    RST = 1'b0;
  endtask

  task automatic checkCleared(input string name);
    checkOutput({name, "_period"}, period, '0);
    checkOutput({name, "_valid"}, WIDTH'(period_valid), '0);
    checkOutput({name, "_stable"}, WIDTH'(period_stable), '0);
    checkOutput({name, "_lost"}, WIDTH'(lost), '0);
  endtask

  initial begin
    int nstable;
    #2;
    // Reset held for three cycles with the reference toggling.
    repeat (3) begin
      clk_in = ~clk_in;
      #TICK;
    end
    clk_in = 1'b0;
    checkCleared("reset");
    RST = 1'b0;
    #(5 * TICK);

    $display("[TB] basic 20-tick measurement");
    clearLog();
    applyStimulus(20, 7);
    #(5 * TICK);
    checkOutput("basic_pulses", WIDTH'(vq_period.size()), WIDTH'(6));
    checkPulse("basic_first", 0, 20, 0);
    checkPulse("basic_third", 2, 20, 0);
    checkPulse("basic_fourth", 3, 20, 1);
    if (vq_cyc.size() >= 2)
      checkOutput("basic_spacing", WIDTH'(vq_cyc[1] - vq_cyc[0]), WIDTH'(20));

    $display("[TB] mid-operation reset");
    pulseReset(1);
    checkCleared("midrst");

    $display("[TB] tolerance 20/21");
    clearLog();
    repeat (4) begin
      applyStimulus(20, 1);
      applyStimulus(21, 1);
    end
    #(5 * TICK);
    checkOutput("tol1_pulses", WIDTH'(vq_period.size()), WIDTH'(7));
    checkPulse("tol1_first", 0, 20, 0);
    checkPulse("tol1_second", 1, 21, 0);
    checkPulse("tol1_third", 2, 20, 0);
    checkPulse("tol1_fourth", 3, 21, 1);
    checkPulse("tol1_last", 6, 20, 1);

    $display("[TB] tolerance 20/22");
    pulseReset(1);
    clearLog();
    repeat (4) begin
      applyStimulus(20, 1);
      applyStimulus(22, 1);
    end
    #(5 * TICK);
    nstable = 0;
    foreach (vq_stable[i]) nstable += vq_stable[i];
    checkOutput("tol2_pulses", WIDTH'(vq_period.size()), WIDTH'(7));
    checkOutput("tol2_stable_count", WIDTH'(nstable), '0);
    checkPulse("tol2_second", 1, 22, 0);

    $display("[TB] frequency change 20 -> 10");
    pulseReset(1);
    clearLog();
    applyStimulus(20, 6);
    applyStimulus(10, 6);
    #(5 * TICK);
    checkOutput("fchg_pulses", WIDTH'(vq_period.size()), WIDTH'(11));
    checkPulse("fchg_last20", 5, 20, 1);
    checkPulse("fchg_first10", 6, 10, 0);
    checkPulse("fchg_third10", 8, 10, 0);
    checkPulse("fchg_fourth10", 9, 10, 1);
    checkPulse("fchg_fifth10", 10, 10, 1);

    $display("[TB] loss and recovery");
    pulseReset(1);
    clearLog();
    applyStimulus(20, 6);
    #(120 * TICK);
    checkOutput("loss_lost", WIDTH'(lost), WIDTH'(1));
    checkOutput("loss_stable", WIDTH'(period_stable), '0);
    checkOutput("loss_period_hold", period, WIDTH'(20));
    checkPulse("loss_stable_before", 3, 20, 1);
    if (vq_cyc.size() == 5)
      checkOutput("loss_delay", WIDTH'(lost_rise_cyc - vq_cyc[4]), WIDTH'(TIMEOUT));
    else
      checkOutput("loss_pulses", WIDTH'(vq_cyc.size()), WIDTH'(5));
    applyStimulus(20, 6);
    #(5 * TICK);
    checkOutput("recov_lost", WIDTH'(lost), '0);
    checkOutput("recov_pulses", WIDTH'(vq_period.size()), WIDTH'(10));
    if (vq_cyc.size() >= 6 && lost_fall_cyc >= 0)
      checkOutput("recov_arm_gap", WIDTH'(vq_cyc[5] - lost_fall_cyc), WIDTH'(20));
    else
      checkOutput("recov_lost_fell", WIDTH'(lost_fall_cyc >= 0), WIDTH'(1));
    checkPulse("recov_first", 5, 20, 0);
    checkPulse("recov_third", 7, 20, 0);
    checkPulse("recov_fourth", 8, 20, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
